// File: rtl/uart_echo_initiator.sv
// UART echo initiator: sends an LFSR byte stream through the transmitter
// and checks each byte echoed back on the receiver.
module uart_echo_initiator #(
  parameter int unsigned NumBytes      = 8,
  parameter logic [7:0]  Seed          = 8'hA5,
  parameter int unsigned TimeoutCycles = 100_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       tx_done_i,
  input  logic       rx_done_i,
  input  logic [7:0] rx_data_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] err_cnt_o,
  output logic [7:0] byte_cnt_o,
  output logic [7:0] last_rx_o
);

  localparam int TW = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_TX,
    S_WAIT_RX,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    lfsr;
  logic [7:0]    lfsr_adv;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          rx_seen;
  logic          err_inc;
  logic          last_byte;
  logic          rx_win;

  assign lfsr_adv  = {lfsr[6:0],
                      lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign tmo_hit   = (tmo_cnt == TW'(TimeoutCycles - 1));
  assign last_byte = (byte_cnt_o == 8'(NumBytes - 1));
  assign tx_data_o = busy_o ? lfsr : 8'h00;

  // echo may complete before tx_done, so capture from SEND onwards
  assign rx_win = (state == S_SEND) ||
                  (state == S_WAIT_TX) ||
                  (state == S_WAIT_RX);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tx_start_o = 1'b0;
    err_inc    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_i) state_nxt = S_SEND;
      end
      S_SEND: begin
        tx_start_o = 1'b1;
        state_nxt  = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tmo_hit) begin
          err_inc   = 1'b1;
          state_nxt = S_NEXT;
        end else if (tx_done_i) begin
          state_nxt = S_WAIT_RX;
        end
      end
      S_WAIT_RX: begin
        if (rx_seen) begin
          state_nxt = S_CHECK;
        end else if (tmo_hit) begin
          err_inc   = 1'b1;
          state_nxt = S_NEXT;
        end
      end
      S_CHECK: begin
        err_inc   = (last_rx_o != lfsr);
        state_nxt = S_NEXT;
      end
      S_NEXT: begin
        state_nxt = last_byte ? S_DONE : S_SEND;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr       <= Seed;
      tmo_cnt    <= '0;
      rx_seen    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
      err_cnt_o  <= 8'h00;
      byte_cnt_o <= 8'h00;
      last_rx_o  <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            err_cnt_o  <= 8'h00;
            byte_cnt_o <= 8'h00;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            lfsr       <= Seed;
            busy_o     <= 1'b1;
          end
        end
        S_SEND: begin
          tmo_cnt <= '0;
          rx_seen <= 1'b0;
        end
        S_WAIT_TX, S_WAIT_RX: begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
        S_NEXT: begin
          if (byte_cnt_o != 8'hFF)
            byte_cnt_o <= byte_cnt_o + 8'h01;
          lfsr <= lfsr_adv;
        end
        S_DONE: begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
          pass_o <= (err_cnt_o == 8'h00);
        end
        default: ;
      endcase
      if (err_inc && err_cnt_o != 8'hFF)
        err_cnt_o <= err_cnt_o + 8'h01;
      if (rx_win && rx_done_i) begin
        rx_seen   <= 1'b1;
        last_rx_o <= rx_data_i;
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_initiator.sv
// Bench for uart_echo_initiator: loopback board model plus a
// scoreboard checking every transmitted byte and every run result.
module tb_uart_echo_initiator;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       tx_done_i = 1'b0;
  logic       rx_done_i = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       tx_start_o;
  logic [7:0] tx_data_o;
  logic       busy_o;
  logic       done_o;
  logic       pass_o;
  logic [7:0] err_cnt_o;
  logic [7:0] byte_cnt_o;
  logic [7:0] last_rx_o;

  always #5 clk = ~clk;

  uart_echo_initiator #(
    .NumBytes     (8),
    .Seed         (8'hA5),
    .TimeoutCycles(1000)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .tx_done_i (tx_done_i),
    .rx_done_i (rx_done_i),
    .rx_data_i (rx_data_i),
    .tx_start_o(tx_start_o),
    .tx_data_o (tx_data_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .pass_o    (pass_o),
    .err_cnt_o (err_cnt_o),
    .byte_cnt_o(byte_cnt_o),
    .last_rx_o (last_rx_o)
  );

  // hand-computed LFSR sequence from A5
  localparam logic [7:0] SEQ [8] = '{
    8'hA5, 8'h4A, 8'h95, 8'h2A,
    8'h54, 8'hA9, 8'h53, 8'hA7
  };

  typedef struct {
    logic [7:0] err;
    logic [7:0] bytes;
    logic       pass;
    logic [7:0] last;
    bit         chk_last;
  } res_t;

  logic [7:0] tx_q [$];
  res_t       res_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // board model: tx_done after tx_lat, echo after rx_lat
  int tx_lat      = 20;
  int rx_lat      = 50;
  bit echo_en     = 1'b1;
  int corrupt_idx = 0;
  int byte_idx    = 0;

  initial begin : board
    logic [7:0] d;
    int n;
    forever begin
      @(negedge clk);
      if (tx_start_o) begin
        d = tx_data_o;
        byte_idx++;
        n = (tx_lat > rx_lat) ? tx_lat : rx_lat;
        for (int k = 1; k <= n; k++) begin
          @(negedge clk);
          tx_done_i = (k == tx_lat);
          rx_done_i = echo_en && (k == rx_lat);
          rx_data_i = (byte_idx == corrupt_idx) ?
                      (d ^ 8'h01) : d;
        end
        @(negedge clk);
        tx_done_i = 1'b0;
        rx_done_i = 1'b0;
      end
    end
  end

  // scoreboard monitor
  initial begin : monitor
    logic done_prev;
    logic [7:0] e;
    res_t r;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start_o) begin
        if (tx_q.size() == 0) begin
          check("tx_unexpected", tx_start_o, 1'b0);
        end else begin
          e = tx_q.pop_front();
          check("tx_data", tx_data_o, e);
        end
      end
      if (done_o && !done_prev) begin
        if (res_q.size() == 0) begin
          check("done_unexpected", done_o, 1'b0);
        end else begin
          r = res_q.pop_front();
          check("err_cnt", err_cnt_o, r.err);
          check("byte_cnt", byte_cnt_o, r.bytes);
          check("pass", pass_o, r.pass);
          check("busy_at_done", busy_o, 1'b0);
          check("tx_q_drained", tx_q.size(), 0);
          if (r.chk_last)
            check("last_rx", last_rx_o, r.last);
        end
      end
      done_prev = done_o;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run(input int tl, input int rl,
                     input bit echo, input int corrupt,
                     input logic [7:0] exp_err,
                     input bit exp_pass, input bit chk_last,
                     input int budget, input int glitch,
                     output int cycles);
    bit g;
    tx_lat      = tl;
    rx_lat      = rl;
    echo_en     = echo;
    corrupt_idx = corrupt;
    byte_idx    = 0;
    for (int i = 0; i < 8; i++) tx_q.push_back(SEQ[i]);
    res_q.push_back('{exp_err, 8'd8, exp_pass,
                      8'hA7, chk_last});
    pulse_start();
    cycles = 0;
    g = 1'b0;
    while (!done_o && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (glitch != 0 && !g && byte_cnt_o == 8'(glitch)) begin
        start_i = 1'b1;
        g = 1'b1;
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    if (!done_o) begin
      check("done_wait", done_o, 1'b1);
      tx_q.delete();
      res_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    int cyc;
    int w;
    repeat (3) @(negedge clk);
    check("rst_tx_start", tx_start_o, 1'b0);
    check("rst_tx_data", tx_data_o, 8'h00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_pass", pass_o, 1'b0);
    check("rst_err", err_cnt_o, 8'h00);
    check("rst_bytes", byte_cnt_o, 8'h00);
    check("rst_last", last_rx_o, 8'h00);
    rst_i = 1'b0;
    @(negedge clk);

    // clean loopback
    run(20, 50, 1, 0, 8'd0, 1, 1, 2000, 0, cyc);
    // third echo corrupted
    run(20, 50, 1, 3, 8'd1, 0, 1, 2000, 0, cyc);
    // no echo: every byte times out
    run(20, 50, 0, 0, 8'd8, 0, 0, 9000, 0, cyc);
    check("tmo_run_len",
          (cyc >= 8000 && cyc <= 8100), 1'b1);
    // echo arrives 2 clk before tx_done
    run(30, 28, 1, 0, 8'd0, 1, 1, 2000, 0, cyc);
    // start pulsed during byte 4
    run(20, 50, 1, 0, 8'd0, 1, 1, 2000, 3, cyc);

    // reset in WAIT_RX of byte 2
    tx_lat = 20; rx_lat = 50; echo_en = 1;
    corrupt_idx = 0; byte_idx = 0;
    for (int i = 0; i < 8; i++) tx_q.push_back(SEQ[i]);
    pulse_start();
    w = 0;
    while (byte_cnt_o != 8'd1 && w < 500) begin
      @(negedge clk); w++;
    end
    w = 0;
    while (!tx_start_o && w < 500) begin
      @(negedge clk); w++;
    end
    repeat (30) @(negedge clk);
    check("mid_busy", busy_o, 1'b1);
    check("mid_tx_q", tx_q.size(), 6);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("mrst_busy", busy_o, 1'b0);
    check("mrst_done", done_o, 1'b0);
    check("mrst_err", err_cnt_o, 8'h00);
    check("mrst_bytes", byte_cnt_o, 8'h00);
    check("mrst_tx_start", tx_start_o, 1'b0);
    tx_q.delete();
    repeat (40) @(negedge clk);
    run(20, 50, 1, 0, 8'd0, 1, 1, 2000, 0, cyc);
    check("res_q_empty", res_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
